// File: rtl/dcache_pkg.sv
// Shared types, widths and byte-lane helper for the data-cache responder.
package dcache_pkg;

  localparam int WORD_W   = 32;
  localparam int OFFSET_W = 2;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} dcache_state_t;

  function automatic logic [3:0] laneStrobe(input logic [OFFSET_W-1:0] offset);
    laneStrobe = 4'b0001 << offset;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped line storage: valid/tag/data per set, async read, byte-masked sync write.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int SETS  = 8,
  parameter int TAG_W = WORD_W - $clog2(SETS) - OFFSET_W,
  localparam int INDEX_W = $clog2(SETS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rdIndex,
  output logic               rdValid,
  output logic [TAG_W-1:0]   rdTag,
  output logic [WORD_W-1:0]  rdData,
  input  logic               wrEn,
  input  logic [INDEX_W-1:0] wrIndex,
  input  logic [TAG_W-1:0]   wrTag,
  input  logic [WORD_W-1:0]  wrData,
  input  logic [3:0]         wrMask
);

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags [SETS];
  logic [WORD_W-1:0] data [SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
    end else if (wrEn) begin
      valid[wrIndex] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are only trusted behind a valid bit.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      tags[wrIndex] <= wrTag;
      for (int unsigned b = 0; b < 4; b++) begin
        if (wrMask[b]) data[wrIndex][8*b +: 8] <= wrData[8*b +: 8];
      end
    end
  end

  assign rdValid = valid[rdIndex];
  assign rdTag   = tags[rdIndex];
  assign rdData  = data[rdIndex];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-through, no-write-allocate data cache for the memory stage.
// Define DCACHE_STATS_EN to add hit_count/miss_count load statistics outputs.
module dcache_responder
  import dcache_pkg::*;
#(
  parameter int SETS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic              byte_en,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [WORD_W-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = WORD_W - INDEX_W - OFFSET_W;

  dcache_state_t state;

  logic [WORD_W-OFFSET_W-1:0] heldWord;
  logic [WORD_W-1:0]          heldWdata;
  logic [3:0]                 heldBe;

  logic [OFFSET_W-1:0] offset;
  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic                lineValid;
  logic [TAG_W-1:0]    lineTag;
  logic [WORD_W-1:0]   lineData;
  logic                hit;
  logic                loadHit;
  logic [WORD_W-1:0]   storeData;
  logic [3:0]          storeBe;

  logic                wrEn;
  logic [INDEX_W-1:0]  wrIndex;
  logic [TAG_W-1:0]    wrTag;
  logic [WORD_W-1:0]   wrData;
  logic [3:0]          wrMask;

  assign offset = addr[OFFSET_W-1:0];
  assign index  = addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign tag    = addr[WORD_W-1:INDEX_W+OFFSET_W];

  assign hit       = lineValid && (lineTag == tag);
  assign loadHit   = (state == IDLE) && req && !we && hit;
  assign storeData = byte_en ? {4{wdata[7:0]}} : wdata;
  assign storeBe   = byte_en ? laneStrobe(offset) : 4'hF;

  // A fill installs the held miss address; a store hit updates the live request.
  assign wrEn    = ((state == FILL) && mem_ready) || ((state == IDLE) && req && we && hit);
  assign wrIndex = (state == FILL) ? heldWord[INDEX_W-1:0] : index;
  assign wrTag   = (state == FILL) ? heldWord[WORD_W-OFFSET_W-1:INDEX_W] : tag;
  assign wrData  = (state == FILL) ? mem_rdata : storeData;
  assign wrMask  = (state == FILL) ? 4'hF : storeBe;

  dcache_array #(
    .SETS  (SETS),
    .TAG_W (TAG_W)
  ) uArray (
    .clk     (clk),
    .rst     (rst),
    .rdIndex (index),
    .rdValid (lineValid),
    .rdTag   (lineTag),
    .rdData  (lineData),
    .wrEn    (wrEn),
    .wrIndex (wrIndex),
    .wrTag   (wrTag),
    .wrData  (wrData),
    .wrMask  (wrMask)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      heldWord  <= '0;
      heldWdata <= '0;
      heldBe    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            heldWord  <= addr[WORD_W-1:OFFSET_W];
            heldWdata <= storeData;
            heldBe    <= storeBe;
            if (we)        state <= WRITE;
            else if (!hit) state <= FILL;
          end
        end
        FILL:    if (mem_ready) state <= IDLE;
        WRITE:   if (mem_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stall is gated by reset so the pipeline is released while reset is held.
  always_comb begin
    stall = 1'b0;
    if (rst) begin
      case (state)
        IDLE:    stall = req && (we || !hit);
        FILL:    stall = 1'b1;
        WRITE:   stall = !mem_ready;
        default: stall = 1'b0;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (loadHit) begin
      rdata = byte_en ? {24'b0, lineData[8*offset +: 8]} : lineData;
    end
  end

  assign mem_req   = (state != IDLE);
  assign mem_we    = (state == WRITE);
  assign mem_addr  = {heldWord, {OFFSET_W{1'b0}}};
  assign mem_wdata = heldWdata;
  assign mem_be    = heldBe;

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (loadHit) hit_count <= hit_count + 32'd1;
      if ((state == IDLE) && req && !we && !hit) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
